// File: rtl/core_pkg.sv
// Shared types for the core pipeline control blocks.
package core_pkg;
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} hz_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// W-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)                             count <= '0;
    else if (inc && (count != {W{1'b1}})) count <= count + W'(1);
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall / branch flush / memory-wait freeze sequencer for the 5-stage core,
// with a saturating count of lost cycles.
module hazard_stall_ctrl
  import core_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             memRead_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_req_mem,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             freeze_all,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_STALLS - 1);

  hz_state_t  state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       luh, mwait, stall_any;

  // x0 never carries a real dependency, so it cannot trigger a stall
  assign luh = valid_id & memRead_ex & (rd_ex != REG_ZERO) &
               ((uses_rs1_id & (rs1_id == rd_ex)) | (uses_rs2_id & (rs2_id == rd_ex)));
  assign mwait = mem_req_mem & ~mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (mwait)                 state_nxt = MEM_WAIT;
        else if (branch_taken_ex)  state_nxt = RUN;
        else if (luh && (LOAD_USE_STALLS > 1)) begin
          state_nxt = LU_STALL;
          cnt_nxt   = LU_INIT;
        end
      end
      LU_STALL: begin
        // a freeze holds the remaining stall count; the hazard stays latched
        if (!mwait) begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || !mem_req_mem) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    flush_id   = 1'b0;
    freeze_all = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mwait) freeze_all = 1'b1;
          else if (branch_taken_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (luh) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        LU_STALL: begin
          if (mwait) freeze_all = 1'b1;
          else begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        MEM_WAIT: freeze_all = ~mem_ready;
        default: ;
      endcase
    end
  end

  assign stall_any = stall_if | bubble_ex | freeze_all;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_any),
    .count (stall_count)
  );
endmodule
